// File: rtl/pwm_pkg.sv
// +-----------------------------------------------------------------+
// | pwm_pkg : shared PWM types and widths                           |
// | Rev 1.0 : initial release                                       |
// +-----------------------------------------------------------------+
`default_nettype none

package pwm_pkg;

  localparam int PWM_WIDTH = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RAMP = 2'd1,
    ST_DONE = 2'd2
  } fade_state_e;

endpackage

`default_nettype wire

// File: rtl/pwm_fade_ctrl.sv
// +-----------------------------------------------------------------+
// | pwm_fade_ctrl : steps the PWM duty toward a target, one step    |
// |                 per qualifying PWM period                       |
// | Rev 1.0 : initial release                                       |
// +-----------------------------------------------------------------+
`default_nettype none

module pwm_fade_ctrl
  import pwm_pkg::*;
#(
  parameter int WIDTH = PWM_WIDTH
) (
  input  logic             pwm_clk,
  input  logic             pwm_reset,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [WIDTH-1:0] cmd_target,
  input  logic [WIDTH-1:0] cmd_step,
  input  logic [WIDTH-1:0] cmd_hold,
  input  logic             cmd_abort,
  input  logic [WIDTH-1:0] pwm_range,
  input  logic             pwm_period,
  output logic [WIDTH-1:0] pwm_value,
  output logic             busy,
  output logic             done
);

  localparam logic [WIDTH-1:0] ONE_W  = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [WIDTH-1:0] ZERO_W = '0;

  fade_state_e      state_q, state_d;
  logic [WIDTH-1:0] value_q, value_d;
  logic [WIDTH-1:0] target_q, target_d;
  logic [WIDTH-1:0] step_q, step_d;
  logic [WIDTH-1:0] hold_q, hold_d;
  logic [WIDTH-1:0] hold_cnt_q, hold_cnt_d;
  logic             done_q;

  // One step toward tgt, saturating at tgt; the extra bit keeps the
  // sum/difference from wrapping before the clamp.
  function automatic logic [WIDTH-1:0] step_toward(
    input logic [WIDTH-1:0] cur,
    input logic [WIDTH-1:0] stp,
    input logic [WIDTH-1:0] tgt
  );
    logic        [WIDTH:0] up_sum;
    logic signed [WIDTH:0] dn_diff;
    up_sum  = {1'b0, cur} + {1'b0, stp};
    dn_diff = $signed({1'b0, cur}) - $signed({1'b0, stp});
    if (tgt >= cur) begin
      step_toward = (up_sum > {1'b0, tgt}) ? tgt : up_sum[WIDTH-1:0];
    end else begin
      step_toward = (dn_diff < $signed({1'b0, tgt})) ? tgt : dn_diff[WIDTH-1:0];
    end
  endfunction

  always_comb begin
    state_d    = state_q;
    value_d    = value_q;
    target_d   = target_q;
    step_d     = step_q;
    hold_d     = hold_q;
    hold_cnt_d = hold_cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (cmd_valid) begin
          target_d   = (cmd_target > pwm_range) ? pwm_range : cmd_target;
          step_d     = (cmd_step == ZERO_W) ? ONE_W : cmd_step;
          hold_d     = cmd_hold;
          hold_cnt_d = ZERO_W;
          state_d    = ST_RAMP;
        end
      end
      ST_RAMP: begin
        // Abort outranks both completion and a coincident step.
        if (cmd_abort) begin
          state_d = ST_IDLE;
        end else if (value_q == target_q) begin
          state_d = ST_DONE;
        end else if (pwm_period) begin
          if (hold_cnt_q == hold_q) begin
            value_d    = step_toward(value_q, step_q, target_q);
            hold_cnt_d = ZERO_W;
            if (value_d == target_q) begin
              state_d = ST_DONE;
            end
          end else begin
            hold_cnt_d = hold_cnt_q + ONE_W;
          end
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge pwm_clk) begin
    if (pwm_reset) begin
      state_q    <= ST_IDLE;
      value_q    <= ZERO_W;
      target_q   <= ZERO_W;
      step_q     <= ONE_W;
      hold_q     <= ZERO_W;
      hold_cnt_q <= ZERO_W;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      value_q    <= value_d;
      target_q   <= target_d;
      step_q     <= step_d;
      hold_q     <= hold_d;
      hold_cnt_q <= hold_cnt_d;
      done_q     <= (state_d == ST_DONE);
    end
  end

  assign cmd_ready = (state_q == ST_IDLE);
  assign busy      = (state_q == ST_RAMP);
  assign pwm_value = value_q;
  assign done      = done_q;

endmodule

`default_nettype wire

// File: tb/tb_pwm_fade_ctrl.sv
// Directed bench for pwm_fade_ctrl with hand-computed expected values.
`default_nettype none

module tb_pwm_fade_ctrl;

  logic       pwm_clk = 1'b0;
  logic       pwm_reset = 1'b1;
  logic       cmd_valid = 1'b0;
  logic       cmd_ready;
  logic [7:0] cmd_target = 8'h00;
  logic [7:0] cmd_step = 8'h00;
  logic [7:0] cmd_hold = 8'h00;
  logic       cmd_abort = 1'b0;
  logic [7:0] pwm_range = 8'hFF;
  logic       pwm_period = 1'b0;
  logic [7:0] pwm_value;
  logic       busy;
  logic       done;

  int checks = 0;
  int errors = 0;

  pwm_fade_ctrl #(.WIDTH(8)) dut (
    .pwm_clk    (pwm_clk),
    .pwm_reset  (pwm_reset),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_target (cmd_target),
    .cmd_step   (cmd_step),
    .cmd_hold   (cmd_hold),
    .cmd_abort  (cmd_abort),
    .pwm_range  (pwm_range),
    .pwm_period (pwm_period),
    .pwm_value  (pwm_value),
    .busy       (busy),
    .done       (done)
  );

  always #5 pwm_clk = ~pwm_clk;

  task automatic tick();
    @(posedge pwm_clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [7:0] t, input logic [7:0] s, input logic [7:0] h);
    cmd_valid  = 1'b1;
    cmd_target = t;
    cmd_step   = s;
    cmd_hold   = h;
    chk("ready_before_cmd", {7'd0, cmd_ready}, 8'd1);
    tick();
    cmd_valid = 1'b0;
    chk("busy_after_cmd", {7'd0, busy}, 8'd1);
  endtask

  // One strobe cycle, then three quiet cycles unless quiet is cleared.
  task automatic strobe(input logic [7:0] exp_val, input string tag, input bit quiet);
    pwm_period = 1'b1;
    tick();
    pwm_period = 1'b0;
    chk(tag, pwm_value, exp_val);
    if (quiet) begin
      repeat (3) tick();
    end
  endtask

  task automatic expect_done(input logic [7:0] final_val);
    chk("done_high", {7'd0, done}, 8'd1);
    chk("busy_low_at_done", {7'd0, busy}, 8'd0);
    chk("value_at_done", pwm_value, final_val);
    tick();
    chk("done_one_cycle", {7'd0, done}, 8'd0);
    chk("ready_after_done", {7'd0, cmd_ready}, 8'd1);
  endtask

  initial begin
    // Reset
    repeat (2) tick();
    pwm_reset = 1'b0;
    chk("rst_value", pwm_value, 8'h00);
    chk("rst_ready", {7'd0, cmd_ready}, 8'd1);
    chk("rst_busy", {7'd0, busy}, 8'd0);
    chk("rst_done", {7'd0, done}, 8'd0);

    // Ramp up 0 -> 0x40 in 0x10 steps
    pwm_range = 8'hFF;
    send(8'h40, 8'h10, 8'h00);
    tick();
    chk("no_strobe_no_step", pwm_value, 8'h00);
    strobe(8'h10, "up_1", 1'b1);
    strobe(8'h20, "up_2", 1'b1);
    strobe(8'h30, "up_3", 1'b1);
    strobe(8'h40, "up_4", 1'b0);
    expect_done(8'h40);

    // Clamp to range 0x80, range change mid-ramp ignored
    pwm_range = 8'h80;
    send(8'hFF, 8'h30, 8'h00);
    pwm_range = 8'h10;
    strobe(8'h70, "clamp_1", 1'b1);
    strobe(8'h80, "clamp_2", 1'b0);
    expect_done(8'h80);
    pwm_range = 8'hFF;

    // Ramp down with oversized step
    send(8'h05, 8'hFF, 8'h00);
    strobe(8'h05, "down_big", 1'b0);
    expect_done(8'h05);
    send(8'h03, 8'h02, 8'h00);
    strobe(8'h03, "down_to_3", 1'b0);
    expect_done(8'h03);

    // Step 0 treated as 1
    send(8'h00, 8'h00, 8'h00);
    strobe(8'h02, "step0_1", 1'b1);
    strobe(8'h01, "step0_2", 1'b1);
    strobe(8'h00, "step0_3", 1'b0);
    expect_done(8'h00);

    // Hold 2: a step only on every third strobe; busy ignores new commands
    send(8'h06, 8'h02, 8'h02);
    strobe(8'h00, "hold_a1", 1'b1);
    strobe(8'h00, "hold_a2", 1'b1);
    strobe(8'h02, "hold_a3", 1'b1);
    cmd_valid  = 1'b1;
    cmd_target = 8'hF0;
    cmd_step   = 8'h80;
    cmd_hold   = 8'h00;
    chk("ready_low_in_ramp", {7'd0, cmd_ready}, 8'd0);
    tick();
    cmd_valid = 1'b0;
    chk("busy_stays", {7'd0, busy}, 8'd1);
    strobe(8'h02, "hold_b1", 1'b1);
    strobe(8'h02, "hold_b2", 1'b1);
    strobe(8'h04, "hold_b3", 1'b1);
    strobe(8'h04, "hold_c1", 1'b1);
    strobe(8'h04, "hold_c2", 1'b1);
    strobe(8'h06, "hold_c3", 1'b0);
    expect_done(8'h06);

    // Target equal to current value: done two cycles after handshake
    send(8'h06, 8'h01, 8'h00);
    tick();
    expect_done(8'h06);

    // Return to 0, then abort after the 0x20 step
    send(8'h00, 8'hFF, 8'h00);
    strobe(8'h00, "back_to_0", 1'b0);
    expect_done(8'h00);
    send(8'h40, 8'h10, 8'h00);
    strobe(8'h10, "ab_1", 1'b1);
    strobe(8'h20, "ab_2", 1'b1);
    cmd_abort = 1'b1;
    tick();
    cmd_abort = 1'b0;
    chk("abort_value", pwm_value, 8'h20);
    chk("abort_busy", {7'd0, busy}, 8'd0);
    chk("abort_ready", {7'd0, cmd_ready}, 8'd1);
    chk("abort_no_done", {7'd0, done}, 8'd0);
    tick();
    chk("abort_no_done_late", {7'd0, done}, 8'd0);

    // Abort coinciding with a strobe: no step
    send(8'h40, 8'h10, 8'h00);
    strobe(8'h30, "abs_1", 1'b1);
    cmd_abort  = 1'b1;
    pwm_period = 1'b1;
    tick();
    cmd_abort  = 1'b0;
    pwm_period = 1'b0;
    chk("abort_strobe_value", pwm_value, 8'h30);
    chk("abort_strobe_busy", {7'd0, busy}, 8'd0);
    chk("abort_strobe_done", {7'd0, done}, 8'd0);

    // Reset mid-ramp
    send(8'h80, 8'h10, 8'h00);
    strobe(8'h40, "rr_1", 1'b0);
    pwm_reset = 1'b1;
    tick();
    pwm_reset = 1'b0;
    chk("midrst_value", pwm_value, 8'h00);
    chk("midrst_busy", {7'd0, busy}, 8'd0);
    chk("midrst_ready", {7'd0, cmd_ready}, 8'd1);
    chk("midrst_done", {7'd0, done}, 8'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
